// File: rtl/dsm_pkg.sv
// Shared constants and helpers for the delta-sigma modulator loop.
package dsm_pkg;

    localparam int unsigned MAX_W = 64;

    // Positive full-scale of a signed word of width w: 2^(w-1)-1.
    function automatic logic signed [MAX_W-1:0] fs_val(input int unsigned w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    // Integrator saturation magnitude for an a-bit register: 2^(a-2)-1.
    function automatic logic signed [MAX_W-1:0] clamp_val(input int unsigned a);
        return (64'sd1 <<< (a - 2)) - 64'sd1;
    endfunction

    // Symmetric clamp of v to [-lim, +lim].
    function automatic logic signed [MAX_W-1:0] sat(
        input logic signed [MAX_W-1:0] v,
        input logic signed [MAX_W-1:0] lim
    );
        if (v > lim) begin
            return lim;
        end else if (v < -lim) begin
            return -lim;
        end
        return v;
    endfunction

    // LSB index of channel c inside a packed multi-channel bus of w-bit lanes.
    function automatic int unsigned ch_lsb(input int unsigned c, input int unsigned w);
        return c * w;
    endfunction

endpackage

// File: rtl/dsm_integrator.sv
// One saturating accumulator stage: value <= sat(value + add - sub) on enable.
module dsm_integrator
    import dsm_pkg::*;
#(
    parameter int unsigned INT_W = 40
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    input  logic                    i_zero_load,
    input  logic signed [INT_W+1:0] i_add,
    input  logic signed [INT_W+1:0] i_sub,
    output logic signed [INT_W-1:0] o_value,
    output logic                    o_clamp_c
);

    localparam int unsigned SUM_W = INT_W + 2;
    localparam logic signed [MAX_W-1:0] LIM = clamp_val(INT_W);

    logic signed [INT_W-1:0] r_value;
    logic signed [SUM_W-1:0] w_sum;
    logic signed [MAX_W-1:0] w_sum_ext;
    logic signed [MAX_W-1:0] w_sat;

    // Headroom of two bits keeps the raw sum from wrapping before the clamp.
    assign w_sum     = SUM_W'(r_value) + i_add - i_sub;
    assign w_sum_ext = MAX_W'(w_sum);
    assign w_sat     = sat(w_sum_ext, LIM);
    assign o_clamp_c = (w_sum_ext > LIM) || (w_sum_ext < -LIM);
    assign o_value   = r_value;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_value <= '0;
        end else if (i_en) begin
            r_value <= i_zero_load ? '0 : INT_W'(w_sat);
        end
    end

endmodule

// File: rtl/dsm_modulator_core.sv
// Multi-channel delta-sigma loop: PCM hold, saturating integrator chain,
// 1-bit quantiser with full-scale feedback and per-channel overflow recovery.
module dsm_modulator_core
    import dsm_pkg::*;
#(
    parameter int unsigned PCM_Bit_Length = 32,
    parameter int unsigned CHANNELS       = 2,
    parameter int unsigned ORDER          = 4,
    parameter int unsigned INT_Bit_Length = 40,
    parameter int unsigned GAIN_SHIFT     = 2,
    parameter int unsigned OVF_LIMIT      = 16
) (
    input  logic                               CLK_I,
    input  logic                               RST_I,
    input  logic [CHANNELS*PCM_Bit_Length-1:0] PCMDATA_I,
    input  logic                               PCM_VALID_I,
    input  logic                               MUTE_I,
    input  logic                               DSD_EN_I,
    output logic [CHANNELS-1:0]                DSD_O,
    output logic                               DSD_VALID_O,
    output logic [CHANNELS-1:0]                RECOVER_O
);

    localparam int unsigned W     = PCM_Bit_Length;
    localparam int unsigned A     = INT_Bit_Length;
    localparam int unsigned SW    = A + 2;
    localparam int unsigned CNT_W = (OVF_LIMIT > 1) ? $clog2(OVF_LIMIT) : 1;

    localparam logic signed [W-1:0] FS     = W'(fs_val(W));
    localparam logic signed [W-1:0] NEG_FS = -FS;
    localparam logic signed [A-1:0] ZERO_A = '0;
    localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(OVF_LIMIT - 1);

    logic [CHANNELS*W-1:0] r_hold;
    logic                  r_valid;

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_hold  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= DSD_EN_I;
            if (PCM_VALID_I) begin
                r_hold <= PCMDATA_I;
            end
        end
    end

    assign DSD_VALID_O = r_valid;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic signed [W-1:0] w_x;
        logic signed [W-1:0] w_y;
        logic signed [W:0]   w_d;
        logic signed [A-1:0] w_stage [ORDER];
        logic [ORDER-1:0]    w_clamp;
        logic                w_y_pos;
        logic                w_recover;
        logic [CNT_W-1:0]    r_cnt;
        logic                r_dsd;
        logic                r_rec;

        assign w_x       = MUTE_I ? '0 : r_hold[ch_lsb(c, W) +: W];
        assign w_y_pos   = (w_stage[ORDER-1] >= ZERO_A);
        assign w_y       = w_y_pos ? FS : NEG_FS;
        assign w_d       = (W+1)'(w_x) - (W+1)'(w_y);
        assign w_recover = (|w_clamp) && (r_cnt == CNT_MAX);

        for (genvar k = 0; k < ORDER; k++) begin : g_st
            logic signed [SW-1:0] w_add;
            logic signed [SW-1:0] w_sub;

            if (k == 0) begin : g_first
                assign w_add = SW'(w_d);
                assign w_sub = '0;
            end else begin : g_next
                assign w_add = SW'(w_stage[k-1]) >>> GAIN_SHIFT;
                assign w_sub = SW'(w_y) >>> GAIN_SHIFT;
            end

            dsm_integrator #(
                .INT_W (A)
            ) u_int (
                .i_clk       (CLK_I),
                .i_rst       (RST_I),
                .i_en        (DSD_EN_I),
                .i_zero_load (w_recover),
                .i_add       (w_add),
                .i_sub       (w_sub),
                .o_value     (w_stage[k]),
                .o_clamp_c   (w_clamp[k])
            );
        end

        // Quantiser output and run-length count of clamped ticks.
        always_ff @(posedge CLK_I) begin
            if (RST_I) begin
                r_cnt <= '0;
                r_dsd <= 1'b0;
                r_rec <= 1'b0;
            end else begin
                r_rec <= 1'b0;
                if (DSD_EN_I) begin
                    r_dsd <= w_y_pos;
                    r_rec <= w_recover;
                    if (!(|w_clamp) || w_recover) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
            end
        end

        assign DSD_O[c]     = r_dsd;
        assign RECOVER_O[c] = r_rec;
    end

endmodule

// File: tb/tb_dsm_modulator_core.sv
// Directed bench for dsm_modulator_core: small 2-channel first-order instance
// plus a single-channel second-order instance for output density.
module tb_dsm_modulator_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: W=8, A=12, ORDER=1, OVF_LIMIT=4, two channels
    logic        a_rst, a_valid, a_mute, a_en;
    logic [15:0] a_pcm;
    logic [1:0]  a_dsd, a_rec;
    logic        a_dval;

    dsm_modulator_core #(
        .PCM_Bit_Length (8),
        .CHANNELS       (2),
        .ORDER          (1),
        .INT_Bit_Length (12),
        .GAIN_SHIFT     (2),
        .OVF_LIMIT      (4)
    ) dut_a (
        .CLK_I       (clk),
        .RST_I       (a_rst),
        .PCMDATA_I   (a_pcm),
        .PCM_VALID_I (a_valid),
        .MUTE_I      (a_mute),
        .DSD_EN_I    (a_en),
        .DSD_O       (a_dsd),
        .DSD_VALID_O (a_dval),
        .RECOVER_O   (a_rec)
    );

    // Instance B: W=16, A=24, ORDER=2, GAIN_SHIFT=1, one channel
    logic        b_rst, b_valid, b_mute, b_en;
    logic [15:0] b_pcm;
    logic [0:0]  b_dsd, b_rec;
    logic        b_dval;

    dsm_modulator_core #(
        .PCM_Bit_Length (16),
        .CHANNELS       (1),
        .ORDER          (2),
        .INT_Bit_Length (24),
        .GAIN_SHIFT     (1),
        .OVF_LIMIT      (16)
    ) dut_b (
        .CLK_I       (clk),
        .RST_I       (b_rst),
        .PCMDATA_I   (b_pcm),
        .PCM_VALID_I (b_valid),
        .MUTE_I      (b_mute),
        .DSD_EN_I    (b_en),
        .DSD_O       (b_dsd),
        .DSD_VALID_O (b_dval),
        .RECOVER_O   (b_rec)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       valid;
        logic [7:0] p0;
        logic [7:0] p1;
        logic       mute;
        int         gap;
        logic [1:0] dsd;   // {ch1, ch0}
    } vec_t;

    vec_t vt[16];

    initial begin
        int first_rec, rec0_cnt, rec1_cnt, ones0, ch1_bad, dval_bad, ones;

        a_rst = 1'b1; a_valid = 1'b0; a_mute = 1'b0; a_en = 1'b0; a_pcm = '0;
        b_rst = 1'b1; b_valid = 1'b0; b_mute = 1'b0; b_en = 1'b0; b_pcm = '0;

        // Idle tone from reset (x=0): alternating +FS/-FS on both channels
        vt[0]  = '{1'b0, 8'd0,   8'd0, 1'b0, 0, 2'b11};
        vt[1]  = '{1'b0, 8'd0,   8'd0, 1'b0, 0, 2'b00};
        vt[2]  = '{1'b0, 8'd0,   8'd0, 1'b0, 0, 2'b11};
        vt[3]  = '{1'b0, 8'd0,   8'd0, 1'b0, 0, 2'b00};
        // Coincident load of ch0=+100: first tick still uses 0
        vt[4]  = '{1'b1, 8'd100, 8'd0, 1'b0, 0, 2'b11};
        vt[5]  = '{1'b0, 8'd0,   8'd0, 1'b0, 0, 2'b00};
        vt[6]  = '{1'b0, 8'd0,   8'd0, 1'b0, 0, 2'b11};
        vt[7]  = '{1'b0, 8'd0,   8'd0, 1'b0, 0, 2'b01};
        vt[8]  = '{1'b0, 8'd0,   8'd0, 1'b0, 0, 2'b11};
        vt[9]  = '{1'b0, 8'd0,   8'd0, 1'b0, 0, 2'b01};
        vt[10] = '{1'b0, 8'd0,   8'd0, 1'b0, 0, 2'b10};
        vt[11] = '{1'b0, 8'd0,   8'd0, 1'b0, 0, 2'b01};
        // Muted sparse ticks: loop input 0 even though ch0 holds +100
        vt[12] = '{1'b0, 8'd0,   8'd0, 1'b1, 3, 2'b11};
        vt[13] = '{1'b0, 8'd0,   8'd0, 1'b1, 3, 2'b01};
        vt[14] = '{1'b0, 8'd0,   8'd0, 1'b1, 3, 2'b10};
        vt[15] = '{1'b0, 8'd0,   8'd0, 1'b1, 3, 2'b01};

        step(); step();
        chk("reset_dsd",   32'(a_dsd),  32'd0);
        chk("reset_valid", 32'(a_dval), 32'd0);
        chk("reset_rec",   32'(a_rec),  32'd0);
        a_rst = 1'b0;
        b_rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            a_valid = vt[i].valid;
            a_pcm   = {vt[i].p1, vt[i].p0};
            a_mute  = vt[i].mute;
            a_en    = 1'b1;
            step();
            chk($sformatf("vec%0d_dsd", i),   32'(a_dsd),  32'(vt[i].dsd));
            chk($sformatf("vec%0d_valid", i), 32'(a_dval), 32'd1);
            chk($sformatf("vec%0d_rec", i),   32'(a_rec),  32'd0);
            a_valid = 1'b0;
            a_en    = 1'b0;
            for (int g = 0; g < vt[i].gap; g++) begin
                step();
                chk($sformatf("vec%0d_gap%0d_valid", i, g), 32'(a_dval), 32'd0);
                chk($sformatf("vec%0d_gap%0d_hold", i, g),  32'(a_dsd),  32'(vt[i].dsd));
            end
        end
        a_mute = 1'b0;

        // Reset mid-stream dominates a coincident tick
        a_en  = 1'b1;
        a_rst = 1'b1;
        step();
        chk("midrst_dsd",   32'(a_dsd),  32'd0);
        chk("midrst_valid", 32'(a_dval), 32'd0);
        chk("midrst_rec",   32'(a_rec),  32'd0);
        a_rst = 1'b0;
        step();
        chk("postrst_t1_dsd",   32'(a_dsd),  32'b11);
        chk("postrst_t1_valid", 32'(a_dval), 32'd1);
        step();
        chk("postrst_t2_dsd", 32'(a_dsd), 32'b00);
        step();
        chk("postrst_t3_dsd", 32'(a_dsd), 32'b11);
        step();
        chk("postrst_t4_dsd", 32'(a_dsd), 32'b00);
        a_en = 1'b0;

        // Overflow recovery: ch0 = -128 drifts down, first clamp at tick 770
        a_rst = 1'b1;
        step();
        a_rst   = 1'b0;
        a_valid = 1'b1;
        a_pcm   = {8'd0, 8'h80};
        step();
        a_valid = 1'b0;
        first_rec = 0; rec0_cnt = 0; rec1_cnt = 0; ones0 = 0; ch1_bad = 0; dval_bad = 0;
        a_en = 1'b1;
        for (int t = 1; t <= 774; t++) begin
            step();
            if (a_rec[0]) begin
                rec0_cnt++;
                if (first_rec == 0) first_rec = t;
            end
            if (a_rec[1]) rec1_cnt++;
            if (t <= 773 && a_dsd[0]) ones0++;
            if (a_dsd[1] != t[0]) ch1_bad++;
            if (!a_dval) dval_bad++;
            if (t == 774) chk("ovf_t774_dsd0", 32'(a_dsd[0]), 32'd1);
        end
        a_en = 1'b0;
        chk("ovf_first_recover_tick", 32'(first_rec), 32'd773);
        chk("ovf_recover_pulses",     32'(rec0_cnt),  32'd1);
        chk("ovf_ch1_recover",        32'(rec1_cnt),  32'd0);
        chk("ovf_ch0_ones",           32'(ones0),     32'd1);
        chk("ovf_ch1_pattern_errs",   32'(ch1_bad),   32'd0);
        chk("ovf_valid_missing",      32'(dval_bad),  32'd0);
        step();
        chk("ovf_after_valid", 32'(a_dval), 32'd0);
        chk("ovf_after_rec",   32'(a_rec),  32'd0);

        // Density of second-order loop at +/- half scale
        b_valid = 1'b1;
        b_pcm   = 16'h3FFF;
        step();
        b_valid = 1'b0;
        ones = 0;
        rec0_cnt = 0;
        b_en = 1'b1;
        for (int t = 0; t < 1024; t++) begin
            step();
            if (b_dsd[0]) ones++;
            if (b_rec[0]) rec0_cnt++;
        end
        b_en = 1'b0;
        chk_rng("density_pos", ones, 764, 772);

        b_rst = 1'b1;
        step();
        b_rst   = 1'b0;
        b_valid = 1'b1;
        b_pcm   = 16'hC001;
        step();
        b_valid = 1'b0;
        ones = 0;
        b_en = 1'b1;
        for (int t = 0; t < 1024; t++) begin
            step();
            if (b_dsd[0]) ones++;
            if (b_rec[0]) rec0_cnt++;
        end
        b_en = 1'b0;
        chk_rng("density_neg", ones, 252, 260);
        chk("density_no_recover", 32'(rec0_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dsm_modulator_core.md
# dsm_modulator_core

Parametrised multi-channel delta-sigma modulator loop. It replaces the purely combinational PCM–DSD differentiator with a complete registered loop, where the differentiator feeds the first stage:
- sample-and-hold of the PCM input;
- a configurable-order chain of saturating integrators;
- a 1-bit quantiser with ±full-scale feedback;
- per-channel overflow recovery.

It sits between the PCM upsampling/interpolation path and the DSD output serialiser. It produces one DSD bit per channel per DSD-rate enable tick.

## Interface
- PCM_Bit_Length, 32, signed PCM sample width W per channel
- CHANNELS, 2, number of independent channels (≥1)
- ORDER, 4, loop order = number of integrators per channel (1..6)
- INT_Bit_Length, 40, integrator register width A (≥ W+3)
- GAIN_SHIFT, 2, arithmetic right shift applied to inter-stage and stage-≥2 feedback terms
- OVF_LIMIT, 16, consecutive clamped ticks that trigger channel recovery (≥1)

Ports:
- CLK_I  input  1  system clock; one clock domain; reset is synchronous and active-high
- RST_I  input  1  synchronous active-high reset
- PCMDATA_I  input  CHANNELS*W  signed samples; channel c occupies bits [c*W +: W]
- PCM_VALID_I  input  1  load PCMDATA_I into the hold register this cycle
- MUTE_I  input  1  force loop input to 0 for all channels; sampled on DSD_EN_I cycles
- DSD_EN_I  input  1  DSD-rate tick; one loop update per asserted cycle
- DSD_O  output  CHANNELS  DSD bit per channel; 1 = +FS, 0 = −FS
- DSD_VALID_O  output  1  one-cycle pulse; DSD_O is new
- RECOVER_O  output  CHANNELS  one-cycle pulse per channel whose integrators were reset by overflow recovery

## Operation
- Constants: FS = 2^(W−1)−1; CLAMP = 2^(A−2)−1; sat(v) clamps v to [−CLAMP, +CLAMP].
- Hold register: loads PCMDATA_I whenever PCM_VALID_I = 1, independent of DSD_EN_I.
- Per channel, on each DSD_EN_I cycle, using pre-edge register values:
  - x = 0 if MUTE_I, else the held sample;
  - y = +FS if I_ORDER ≥ 0, else −FS;
  - d = x − y, computed in W+1 bits and sign-extended to A+2 bits;
  - I_1 ← sat(I_1 + d);
  - I_k ← sat(I_k + (I_{k−1} >>> GAIN_SHIFT) − (y >>> GAIN_SHIFT)) for k = 2..ORDER, using the old I_{k−1};
  - DSD_O[c] ← (y == +FS).
- All sums are computed at A+2 bits before sat; no wrap-around is permitted.
- Recovery counter per channel, 0..OVF_LIMIT−1:
  - on a tick where any stage clamped, the counter increments;
  - on a tick with no clamp, the counter clears.
- On a clamped tick with counter = OVF_LIMIT−1:
  - all of that channel's integrators load 0 instead of their clamped values;
  - the counter clears;
  - RECOVER_O[c] pulses.
  - DSD_O[c] for that tick is still the pre-update y.
- Channels are fully independent; recovery of one channel never disturbs another.
- No update occurs and no output changes while DSD_EN_I = 0.

## Timing
- Reset values:
  - integrators, hold register, counters: 0;
  - DSD_O = 0, DSD_VALID_O = 0, RECOVER_O = 0.
- Latency: DSD_O, DSD_VALID_O and RECOVER_O are registered and valid in the cycle after DSD_EN_I. DSD_VALID_O is high for exactly one cycle per tick.
- Back-to-back DSD_EN_I (every cycle) is supported at full rate.
- If PCM_VALID_I and DSD_EN_I coincide, the update uses the previously held sample; the new sample applies from the next tick.
- MUTE_I is taken on the tick cycle only. The integrators are not cleared by mute.
- RST_I dominates DSD_EN_I and PCM_VALID_I. A reset mid-stream zeroes all state, and the first tick after reset outputs DSD_O = all 1s (I_ORDER = 0 ⇒ +FS).

## Structure
- Package dsm_pkg:
  - FS and CLAMP constant functions parametrised on width;
  - a sat() function;
  - the channel-slice index helper.
- Sub-module dsm_integrator: one saturating accumulator stage. It has inputs for the add term and the subtract term, an enable and a zero-load, and outputs the value and a clamp flag.
- The top level generates a CHANNELS × ORDER array of stages, plus per-channel quantiser and recovery counter.

## Test plan
- **Idle tone.** W=8, ORDER=1, x=0, DSD_EN_I every cycle after reset → DSD_O = 1,0,1,0,… and I_1 = −127,0,−127,….
- **Density.** W=16, ORDER=2, GAIN_SHIFT=1, x=+16383 held, 1024 ticks → count of 1s = 768 ± 4. With x=−16383 → count = 256 ± 4.
- **Overflow recovery.** W=8, A=12, ORDER=1, OVF_LIMIT=4, x=−128 → I_1 = −255 after tick 1, then decreases by 1 per tick. The first clamp is at tick 770. On tick 773 RECOVER_O pulses and I_1 = 0; the other channel (x=0) is unaffected.
- **Coincident load.** PCM_VALID_I and DSD_EN_I in the same cycle with x changing 0→+100 → that tick uses 0; the next tick uses +100.
- **Mute and sparse ticks.** DSD_EN_I every 4th cycle, MUTE_I high → DSD_VALID_O pulses exactly 1 cycle after each tick. Outputs hold between ticks. Loop input is 0 regardless of the hold register.
- **Reset mid-stream.** Assert RST_I for 1 cycle during a running stream → the next cycle shows all outputs 0. The first subsequent tick yields DSD_O = all 1s.
